// File: rtl/uart_tx_fifo_if.sv
// Byte-push handshake between a producer and the UART transmitter FIFO.
//   tx_valid : producer presents a byte on tx_data
//   tx_data  : byte to transmit
//   tx_ready : transmitter FIFO can accept a byte this cycle
// A byte transfers on a rising clock edge where tx_valid && tx_ready.
interface uart_tx_fifo_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a small byte FIFO, so on-chip producers can
// queue bytes through a valid/ready handshake without stalling on the line.
//
// Ports:
//   clk        : system clock, all logic on the rising edge
//   rst_n      : asynchronous active-low reset; aborts any frame in flight
//                and discards queued bytes
//   bus        : slave side of the byte handshake (tx_valid/tx_data/tx_ready)
//   TX         : registered serial output, idles high
//   busy       : a frame is in flight or the FIFO holds bytes
//   fifo_count : bytes queued, not counting the byte being serialized
//
// Frame: start bit (0), 8 data bits LSB first, stop bit (1); every bit lasts
// BAUD_DIV = CLK_FREQ/UART_BPS clocks. Frames are sent back-to-back while
// the FIFO has data.
module uart_tx_fifo #(
  parameter  int CLK_FREQ   = 50_000_000,
  parameter  int UART_BPS   = 9600,
  parameter  int FIFO_DEPTH = 8,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_fifo_if.slave       bus,
  output logic                TX,
  output logic                busy,
  output logic [CW-1:0]       fifo_count
);

  localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
  localparam int BW       = $clog2(BAUD_DIV);
  localparam int PW       = $clog2(FIFO_DEPTH);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------
  logic [7:0]    mem [0:FIFO_DEPTH-1];
  logic [7:0]    rd_data_reg;     // byte currently being serialized
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic push;
  logic pop;
  logic empty;

  // tx_ready comes straight from the registered count, so a pop while full
  // only frees a slot from the following edge on.
  assign bus.tx_ready = (count_reg != COUNT_MAX);
  assign empty        = (count_reg == '0);
  assign push         = bus.tx_valid && bus.tx_ready;

  // Storage has no reset so it maps onto RAM; the head byte is captured in a
  // register on the pop edge and held there for the whole frame. A pop needs
  // a non-empty FIFO and a push needs a non-full one, so the read and write
  // addresses never coincide on the same edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.tx_data;
    end
    if (pop) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------
  state_t        state_reg,   state_next;
  logic          tx_reg,      tx_next;
  logic [BW-1:0] baud_reg,    baud_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic          baud_done;

  assign baud_done = (baud_reg == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      tx_reg      <= 1'b1;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      tx_reg      <= tx_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tx_next      = tx_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    pop          = 1'b0;

    // Outside IDLE the baud counter free-runs and wraps on every bit
    // boundary, so each bit is exactly BAUD_DIV clocks long.
    if (state_reg != S_IDLE) begin
      baud_next = baud_done ? '0 : baud_reg + BW'(1);
    end

    case (state_reg)
      S_IDLE: begin
        tx_next   = 1'b1;
        baud_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          tx_next    = 1'b0;
          state_next = S_START;
        end
      end

      S_START: begin
        if (baud_done) begin
          tx_next      = rd_data_reg[0];
          bit_idx_next = '0;
          state_next   = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_done) begin
          if (bit_idx_reg != 3'd7) begin
            // Walking an index over the held byte is equivalent to shifting
            // it right and sending bit 0.
            tx_next      = rd_data_reg[bit_idx_reg + 3'd1];
            bit_idx_next = bit_idx_reg + 3'd1;
          end else begin
            tx_next    = 1'b1;
            state_next = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (baud_done) begin
          if (!empty) begin
            // Next start bit follows the stop bit with no idle gap.
            pop        = 1'b1;
            tx_next    = 1'b0;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign TX         = tx_reg;
  assign busy       = (state_reg != S_IDLE) || (count_reg != '0);
  assign fifo_count = count_reg;

endmodule
